// File: rtl/lsb_one_isolate_log2.sv
// ----------------------------------------------------------------------------
// lsb_one_isolate_log2
//   Registered rightmost-1 finder. It isolates the least-significant set bit
//   of word_in as a one-hot mask, converts that mask to its bit index (the
//   trailing-zero count) and flags the all-zero input. There is one pipeline
//   stage and no backpressure.
//
// Parameters
//   WORD_WIDTH     width of word_in, lsb_mask_out and index_out (>= 2)
//
// Ports
//   clock          rising-edge clock
//   clear          synchronous active-high reset; overrides valid_in
//   valid_in       word_in is valid this cycle
//   word_in        input word
//   valid_out      registered outputs are valid (valid_in delayed one cycle)
//   lsb_mask_out   one-hot rightmost 1 of the sampled word (0 if word was 0)
//   index_out      bit index of the rightmost 1, zero-extended
//   undefined_out  1 when the sampled word was 0
//
// Build option
//   LSB_ONE_ISOLATE_LOG2_ZERO_COUNT_EN
//     defined:   a zero word reports index_out = WORD_WIDTH, which is the
//                full trailing-zero count
//     undefined: a zero word reports index_out = 0
//   undefined_out is raised for a zero word in both builds.
// ----------------------------------------------------------------------------

// One bit of the log2 result: OR of every mask bit whose position has bit BIT
// set. The mask is one-hot or zero, so this OR gives the exact index bit.
module lsb_one_isolate_log2_idx_bit #(
    parameter int WORD_WIDTH = 8,
    parameter int BIT        = 0
) (
    input  logic [WORD_WIDTH-1:0] mask,
    output logic                  idx_bit
);
    always_comb begin
        idx_bit = 1'b0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (((i >> BIT) & 1) == 1) idx_bit = idx_bit | mask[i];
        end
    end
endmodule

module lsb_one_isolate_log2 #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  valid_in,
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic                  valid_out,
    output logic [WORD_WIDTH-1:0] lsb_mask_out,
    output logic [WORD_WIDTH-1:0] index_out,
    output logic                  undefined_out
);
    // Wide enough to hold WORD_WIDTH itself, which is needed for the zero
    // count. Bits of index_out above this width are always 0.
    localparam int IDX_W  = $clog2(WORD_WIDTH + 1);
    localparam int STAGES = 1;

    // ---------------------------------------------------------------- comb
    logic [WORD_WIDTH-1:0] mask_c;
    logic [IDX_W-1:0]      or_idx_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  zero_c;

    // x & -x keeps only the lowest set bit (negation is modulo 2^WORD_WIDTH)
    assign mask_c = word_in & (~word_in + WORD_WIDTH'(1));
    assign zero_c = (mask_c == '0);

    for (genvar b = 0; b < IDX_W; b++) begin : g_idx
        lsb_one_isolate_log2_idx_bit #(
            .WORD_WIDTH (WORD_WIDTH),
            .BIT        (b)
        ) u_idx_bit (
            .mask    (mask_c),
            .idx_bit (or_idx_c[b])
        );
    end

`ifdef LSB_ONE_ISOLATE_LOG2_ZERO_COUNT_EN
    // The OR tree gives 0 for a zero mask, so the count is substituted here
    assign idx_c = zero_c ? IDX_W'(WORD_WIDTH) : or_idx_c;
`else
    assign idx_c = or_idx_c;
`endif

    // ---------------------------------------------------------------- regs
    // Declaration initialisers give the same values at power-up as clear does
    logic [STAGES:1]       vld_pipe  = '0;
    logic [WORD_WIDTH-1:0] mask_q    = '0;
    logic [IDX_W-1:0]      idx_q     = '0;
    logic                  undef_q   = 1'b0;

    always_ff @(posedge clock) begin
        if (clear) begin
            // A word presented in the clear cycle is dropped
            vld_pipe <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            undef_q  <= 1'b0;
        end else begin
            vld_pipe[1] <= valid_in;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            // Data only moves on a valid word; otherwise the last result holds
            if (valid_in) begin
                mask_q  <= mask_c;
                idx_q   <= idx_c;
                undef_q <= zero_c;
            end
        end
    end

    assign valid_out     = vld_pipe[STAGES];
    assign lsb_mask_out  = mask_q;
    assign index_out     = WORD_WIDTH'(idx_q);
    assign undefined_out = undef_q;

endmodule

// File: tb/tb_lsb_one_isolate_log2.sv
module tb_lsb_one_isolate_log2;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] word_in = '0;
    logic         valid_out;
    logic [W-1:0] lsb_mask_out;
    logic [W-1:0] index_out;
    logic         undefined_out;

    lsb_one_isolate_log2 #(.WORD_WIDTH(W)) dut (
        .clock         (clock),
        .clear         (clear),
        .valid_in      (valid_in),
        .word_in       (word_in),
        .valid_out     (valid_out),
        .lsb_mask_out  (lsb_mask_out),
        .index_out     (index_out),
        .undefined_out (undefined_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] idx;
        logic         undef;
        int           due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic clr_seen = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        clr_seen <= clear;
    end

    // Reference: scan upward for the first set bit
    function automatic exp_t model(input logic [W-1:0] w);
        exp_t e;
        e.mask  = '0;
        e.undef = 1'b1;
`ifdef LSB_ONE_ISOLATE_LOG2_ZERO_COUNT_EN
        e.idx   = W;
`else
        e.idx   = 0;
`endif
        e.due   = 0;
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin
                e.mask  = 1 << i;
                e.idx   = i;
                e.undef = 1'b0;
                break;
            end
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] w, input logic c);
        exp_t e;
        @(posedge clock);
        #1;
        valid_in = v;
        word_in  = w;
        clear    = c;
        if (v && !c) begin
            e     = model(w);
            e.due = cyc + 1;
            q.push_back(e);
        end
    endtask

    // Monitor: pops on every valid output; while invalid, data must hold the
    // last result (or zero after a clear).
    logic [W-1:0] held_mask = '0;
    logic [W-1:0] held_idx  = '0;
    logic         held_undef = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (clr_seen) begin
            held_mask  = '0;
            held_idx   = '0;
            held_undef = 1'b0;
        end
        checks++;
        if (valid_out) begin
            if (clr_seen || q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d clr=%0b queued=%0d", cyc, clr_seen, q.size());
            end else begin
                e = q.pop_front();
                if (cyc != e.due || lsb_mask_out !== e.mask || index_out !== e.idx ||
                    undefined_out !== e.undef) begin
                    errors++;
                    $display("FAIL result cyc=%0d got mask=%h idx=%0d undef=%0b, want cyc=%0d mask=%h idx=%0d undef=%0b",
                             cyc, lsb_mask_out, index_out, undefined_out, e.due, e.mask, e.idx, e.undef);
                end
                held_mask  = e.mask;
                held_idx   = e.idx;
                held_undef = e.undef;
            end
        end else begin
            if (q.size() != 0 && q[0].due <= cyc) begin
                errors++;
                $display("FAIL missing_valid cyc=%0d got valid_out=0, want result due at %0d", cyc, q[0].due);
            end else if (lsb_mask_out !== held_mask || index_out !== held_idx ||
                         undefined_out !== held_undef) begin
                errors++;
                $display("FAIL hold cyc=%0d got mask=%h idx=%0d undef=%0b, want mask=%h idx=%0d undef=%0b",
                         cyc, lsb_mask_out, index_out, undefined_out, held_mask, held_idx, held_undef);
            end
        end
    end

    initial begin
        logic [W-1:0] w;
        // 1: reset, then idle
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        // 2: all ones
        drive(1, 8'hFF, 0);
        // 3: back-to-back
        drive(1, 8'h0C, 0);
        drive(1, 8'h18, 0);
        drive(1, 8'h80, 0);
        // 4: zero word
        drive(1, 8'h00, 0);
        // 5: valid then idle with a different word (must hold)
        drive(1, 8'h12, 0);
        drive(0, 8'h01, 0);
        drive(0, 8'h01, 0);
        // 6: valid together with clear is dropped
        drive(1, 8'h40, 1);
        drive(0, 8'h00, 0);
        // MSB only after a zero, then clear mid-stream
        drive(1, 8'h00, 0);
        drive(1, 8'h80, 0);
        drive(1, 8'h05, 1);
        drive(1, 8'h06, 0);
        // Exhaustive sweep with random gaps and occasional clears
        for (int i = 0; i < 256; i++) begin
            w = i[W-1:0];
            while ($urandom_range(0, 3) == 0) drive(0, W'($urandom), 0);
            drive(1, w, ($urandom_range(0, 31) == 0));
        end
        // Random words, random valid/clear mix
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 40) == 0));
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        @(posedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d results outstanding, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
